// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: bundles the host command/response port and the APB
// requester pins of apb_master_bridge.
//   master modport - the bridge view: takes commands and APB slave returns,
//                    drives cmd_ready, the response and the APB request pins.
//   slave  modport - the environment view (host + APB slave), mirror image.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSELx;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSELx, PENABLE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns each accepted valid/ready command into one APB
// transfer (SETUP, then ACCESS until PREADY or timeout) and returns a
// one-cycle response pulse carrying read data or a timeout flag.
// Ports:
//   pclk   - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - apb_master_bridge_if.master (command, response, APB pins)
// Every output is a register; the always_comb block computes next values.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic pclk,
  input  logic reset,
  apb_master_bridge_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count of low-PREADY ACCESS edges at which the transfer is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_cmd_ready, w_cmd_ready;
  logic              r_rsp_valid, w_rsp_valid;
  logic              r_rsp_timeout, w_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_pwrite, w_pwrite;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_cmd_ready   <= w_cmd_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_timeout <= w_rsp_timeout;
      r_rsp_rdata   <= w_rsp_rdata;
      r_paddr       <= w_paddr;
      r_pwdata      <= w_pwdata;
      r_pwrite      <= w_pwrite;
      r_psel        <= w_psel;
      r_penable     <= w_penable;
    end
  end

  always_comb begin
    // Response fields are pulses; address/data/direction hold their value.
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_cmd_ready   = r_cmd_ready;
    w_rsp_valid   = 1'b0;
    w_rsp_timeout = 1'b0;
    w_rsp_rdata   = '0;
    w_paddr       = r_paddr;
    w_pwdata      = r_pwdata;
    w_pwrite      = r_pwrite;
    w_psel        = r_psel;
    w_penable     = r_penable;
    case (r_state)
      S_IDLE: begin
        // cmd_ready is registered high throughout IDLE, so this is the accept.
        if (bus.cmd_valid) begin
          w_paddr     = bus.cmd_addr;
          w_pwdata    = bus.cmd_wdata;
          w_pwrite    = bus.cmd_write;
          w_cmd_ready = 1'b0;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
          w_state     = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable = 1'b1;
        w_cnt     = '0;
        w_state   = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY is checked first so a completion on the last allowed cycle
        // beats the timeout.
        if (bus.PREADY) begin
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : bus.PRDATA;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_valid   = 1'b1;
          w_rsp_timeout = 1'b1;
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_cmd_ready   = 1'b1;
          w_state       = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_cmd_ready = 1'b1;
        w_state     = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PSELx       = r_psel;
  assign bus.PENABLE     = r_penable;
endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic pclk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;  // value the slave presents on PRDATA
    int          waits;   // low-PREADY ACCESS cycles before PREADY rises
    int          lat;     // negedge index (after accept edge) of rsp_valid
    logic        to;
    logic [31:0] rdata;
    int          psel_n;
    int          pen_n;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One command; the slave model drives PREADY from the ACCESS-cycle count.
  // PREADY is forced high during SETUP to show it is ignored there.
  task automatic run_vec(input vec_t v, input string tag);
    int  a, lat, ps, pe, unstable;
    bit  got;
    logic        to;
    logic [31:0] rd;
    @(negedge pclk);
    chk({tag, " ready"}, bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.PRDATA    = v.prdata;
    bus.PREADY    = 1'b0;
    @(posedge pclk);
    a = 0; lat = 0; ps = 0; pe = 0; unstable = 0; got = 0; to = 1'bx; rd = 'x;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge pclk);
      if (k == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.wr;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
      end
      if (bus.rsp_valid) begin
        got = 1; lat = k; to = bus.rsp_timeout; rd = bus.rsp_rdata;
      end
      if (bus.PSELx) begin
        ps++;
        if (bus.PADDR !== v.addr || bus.PWDATA !== v.wdata || bus.PWRITE !== v.wr)
          unstable++;
      end
      if (bus.PENABLE) begin
        pe++;
        a++;
        bus.PREADY = (a > v.waits);
      end else begin
        bus.PREADY = bus.PSELx;
      end
    end
    bus.PREADY = 1'b0;
    chk({tag, " latency"},  lat, v.lat);
    chk({tag, " timeout"},  to, v.to);
    chk({tag, " rdata"},    rd, v.rdata);
    chk({tag, " psel_cyc"}, ps, v.psel_n);
    chk({tag, " pen_cyc"},  pe, v.pen_n);
    chk({tag, " stable"},   unstable, 0);
    @(negedge pclk);
    chk({tag, " rsp_once"},  bus.rsp_valid, 1'b0);
    chk({tag, " psel_after"}, bus.PSELx, 1'b0);
    chk({tag, " idle_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, " paddr_hold"}, bus.PADDR, v.addr);
  endtask

  initial begin
    int nrsp;
    logic [7:0] rv, rdy, sel;
    logic [31:0] rd3, rd6, pa4;
    logic        pw4;

    //            wr    addr          wdata         prdata        waits lat to    rdata         psel pen
    vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_00A5, 32'hFFFF_0000, 0,    3,  1'b0, 32'h0,        2,   1};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_003C, 4,    7,  1'b0, 32'h0000_003C, 6,   5};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF, 8,    10, 1'b1, 32'h0,        9,   8};
    vecs[3] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 32'h1234_5678, 7,    10, 1'b0, 32'h1234_5678, 9,   8};
    vecs[4] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'h5555_AAAA, 2,    5,  1'b0, 32'h0,        4,   3};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b1; bus.cmd_addr = 32'hFFFF_FFFF;
    bus.cmd_wdata = 32'hFFFF_FFFF; bus.PRDATA = 32'h0; bus.PREADY = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst psel",    bus.PSELx, 1'b0);
    chk("rst penable", bus.PENABLE, 1'b0);
    chk("rst rsp",     bus.rsp_valid, 1'b0);
    chk("rst ready",   bus.cmd_ready, 1'b1);
    chk("rst paddr",   bus.PADDR, 32'h0);
    chk("rst pwdata",  bus.PWDATA, 32'h0);
    chk("rst pwrite",  bus.PWRITE, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: write then read, cmd_valid held, PREADY tied high.
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h50;
    bus.cmd_wdata = 32'h11; bus.PREADY = 1'b1; bus.PRDATA = 32'h77;
    @(posedge pclk);
    rv = '0; rdy = '0; sel = '0; rd3 = '0; rd6 = '0; pa4 = '0; pw4 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge pclk);
      rv[k] = bus.rsp_valid; rdy[k] = bus.cmd_ready; sel[k] = bus.PSELx;
      if (k == 1) begin bus.cmd_write = 1'b0; bus.cmd_addr = 32'h54; end
      if (k == 3) rd3 = bus.rsp_rdata;
      if (k == 4) begin pa4 = bus.PADDR; pw4 = bus.PWRITE; bus.cmd_valid = 1'b0; end
      if (k == 6) rd6 = bus.rsp_rdata;
    end
    chk("b2b rsp_pattern",   rv[7:1],  7'b0100100);
    chk("b2b ready_at_rsp",  rdy[3],   1'b1);
    chk("b2b psel_pattern",  sel[7:1], 7'b0011011);
    chk("b2b second_addr",   pa4, 32'h54);
    chk("b2b second_dir",    pw4, 1'b0);
    chk("b2b write_rdata",   rd3, 32'h0);
    chk("b2b read_rdata",    rd6, 32'h77);
    bus.PREADY = 1'b0;

    // Reset pulsed mid-ACCESS: transfer dropped silently.
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40; bus.PREADY = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    chk("rstmid in_access", bus.PENABLE, 1'b1);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    chk("rstmid psel",    bus.PSELx, 1'b0);
    chk("rstmid penable", bus.PENABLE, 1'b0);
    chk("rstmid ready",   bus.cmd_ready, 1'b1);
    chk("rstmid rsp",     bus.rsp_valid, 1'b0);
    chk("rstmid paddr",   bus.PADDR, 32'h0);
    nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge pclk);
      if (bus.rsp_valid) nrsp++;
    end
    chk("rstmid no_rsp", nrsp, 0);
    run_vec(vecs[1], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that drives the peripheral bus on behalf of a simple valid/ready command port. It turns each accepted command into one APB transfer: a SETUP phase, then an ACCESS phase that lasts until PREADY. It returns the read data, or a timeout flag, as a one-cycle response pulse. It sits between the host-side logic and APB slaves such as the UART interface, whose PREADY stays low while its FIFO is full or empty.

## Interface

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR
- DATA_W, 32, width of write/read data paths
- TIMEOUT, 255, maximum number of ACCESS cycles with PREADY low before abort; legal range 1..65535

Ports:
- pclk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts
- rsp_timeout  out  1  qualifies rsp_valid; 1 = transfer aborted
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PWRITE  out  1  APB direction
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation

- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- **IDLE**
  - cmd_ready=1, PSELx=0, PENABLE=0.
  - On cmd_valid=1, latch cmd_addr, cmd_wdata and cmd_write into PADDR, PWDATA and PWRITE, then go to SETUP.
  - cmd_* inputs are ignored in every other state.
- **SETUP**
  - PSELx=1, PENABLE=0, cmd_ready=0.
  - Lasts exactly one cycle, then goes to ACCESS. PREADY is ignored in SETUP.
- **ACCESS**
  - PSELx=1, PENABLE=1.
  - The wait counter is cleared on entry and increments on each ACCESS edge where PREADY=0.
  - If PREADY=1 at an edge, the transfer completes: rsp_valid=1, rsp_timeout=0, rsp_rdata = PRDATA for a read or 0 for a write. PSELx and PENABLE drop to 0 and the FSM returns to IDLE.
  - Otherwise, if PREADY=0 and the counter equals TIMEOUT-1, the transfer aborts: rsp_valid=1, rsp_timeout=1, rsp_rdata=0, PSELx and PENABLE drop, and the FSM returns to IDLE.
  - PREADY=1 on the final allowed cycle wins over the timeout.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS, and keep their last value in IDLE.
- The wait counter width is clog2(TIMEOUT+1) and it never wraps, because it is cleared on entry to ACCESS.
- rsp_valid is high for exactly one cycle per accepted command. There is no backpressure on the response port.
- Reset, whether idle or mid-transfer, forces IDLE and clears all of the following:
  - outputs: rsp_valid, rsp_timeout, rsp_rdata, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  - wait counter
  - cmd_ready is 1 in the first cycle after reset.
  - A transfer aborted by reset produces no response.

## Timing

- Command accepted at edge N: SETUP is visible in cycle N→N+1 and ACCESS from edge N+1.
- Zero wait states (PREADY=1 at edge N+2): rsp_valid is high in cycle N+2→N+3, together with cmd_ready=1.
- Each wait state (PREADY=0 in ACCESS) adds one cycle.
- A timeout asserts rsp_valid after exactly TIMEOUT ACCESS cycles, at edge N+1+TIMEOUT.
- Back-to-back: a command presented during the rsp_valid cycle is accepted, giving a peak rate of one transfer per 3 cycles.
- PREADY and PRDATA are sampled only on ACCESS edges.

## Test plan

- **Write, zero wait:** cmd write addr 0x0000_0004, data 0x0000_00A5, PREADY tied 1 -> PSELx high for 2 cycles; PENABLE high for 1 cycle; PWDATA=0xA5 and PWRITE=1 throughout; rsp_valid pulse 3 cycles after accept with rsp_timeout=0 and rsp_rdata=0.
- **Read, 4 wait states:** PREADY low for 4 ACCESS cycles then high with PRDATA=0x0000_003C -> PENABLE high for 5 cycles; rsp_rdata=0x3C; rsp_valid for exactly 1 cycle; PADDR stable throughout.
- **Timeout, TIMEOUT=8:** PREADY held 0 -> abort after 8 ACCESS cycles; rsp_timeout=1; rsp_rdata=0; PSELx=0 the next cycle; FSM returns to IDLE.
- **Boundary, TIMEOUT=8:** PREADY rises on the 8th ACCESS cycle -> normal completion with rsp_timeout=0.
- **Back-to-back:** write then read with cmd_valid held high and PREADY=1 -> second accept in the rsp_valid cycle of the first; transfers 3 cycles apart; no PSELx gap shorter than 1 cycle.
- **Reset mid-ACCESS:** reset pulsed during ACCESS -> next cycle PSELx=0, PENABLE=0, cmd_ready=1; no rsp_valid; a following read completes normally.
